// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forwarding sequencer for the 5-stage RV32I pipeline: reset flush,
// load-use and branch hazards, and a data-memory wait state with a sticky timeout flag.
module pipeline_hazard_controller #(
    parameter int RESET_FLUSH_CYCLES = 4,
    parameter int MEM_TIMEOUT        = 255,
    parameter int CNT_W              = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       DmemReady,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       DmemReq,
    output logic       PipeActive,
    output logic       MemErr
);
    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(RESET_FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEM_TO    = CNT_W'(MEM_TIMEOUT);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_init_cnt, r_wait_cnt, w_wait_nxt;
    logic             r_mem_err;
    logic             w_active, w_lw_stall, w_mem_stall;
    logic [1:0]       w_fwd_a, w_fwd_b;

    assign w_active    = (r_state != INIT);
    assign w_lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_mem_stall = MemReqM && !DmemReady;

    // M-stage result is newer than W, so it wins when both match.
    assign w_fwd_a = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                     (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    assign w_fwd_b = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                     (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;

    always_comb begin
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        StallF     = 1'b1;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b1;
        FlushE     = 1'b1;
        FlushW     = 1'b1;
        DmemReq    = 1'b0;
        PipeActive = 1'b0;
        if (w_active) begin
            ForwardAE  = w_fwd_a;
            ForwardBE  = w_fwd_b;
            DmemReq    = MemReqM;
            PipeActive = 1'b1;
            // A pending memory access freezes everything; hazards are re-evaluated afterwards.
            if (w_mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b0;
                FlushW = 1'b1;
            end else begin
                StallF = w_lw_stall;
                StallD = w_lw_stall;
                FlushD = PCSrcE;
                FlushE = w_lw_stall || PCSrcE;
                FlushW = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = '0;
        case (r_state)
            INIT:     if (r_init_cnt == INIT_LAST) w_state_nxt = RUN;
            RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (w_mem_stall)
                    w_wait_nxt = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
                else
                    w_state_nxt = RUN;
            end
            default:  w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (r_state == INIT)
                r_init_cnt <= r_init_cnt + CNT_W'(1);
            if (w_state_nxt == MEM_WAIT && w_wait_nxt >= MEM_TO)
                r_mem_err <= 1'b1;
        end
    end

    assign MemErr = r_mem_err;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed vectors plus hand-written reset, memory-wait and timeout sequences
// for pipeline_hazard_controller (RESET_FLUSH_CYCLES=4, MEM_TIMEOUT=8).
module tb_pipeline_hazard_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, DmemReady;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic       DmemReq, PipeActive, MemErr;

    pipeline_hazard_controller #(
        .RESET_FLUSH_CYCLES(4), .MEM_TIMEOUT(8), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .DmemReady(DmemReady),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .DmemReq(DmemReq), .PipeActive(PipeActive), .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    // Bundle order: {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, DmemReq, PipeActive}
    localparam logic [12:0] INIT_EXP = 13'b00_00_1000_111_0_0;
    localparam logic [12:0] MEMS_EXP = 13'b00_00_1111_001_1_1;

    typedef struct {
        string       name;
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic        rwm, rww, ld, pc, mreq, rdy;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [12:0] run_exp(logic [1:0] fa, logic [1:0] fb, logic sf, logic sd,
                                            logic fd, logic fe, logic dq);
        return {fa, fb, sf, sd, 1'b0, 1'b0, fd, fe, 1'b0, dq, 1'b1};
    endfunction

    function automatic logic [12:0] outs();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushW, DmemReq, PipeActive};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic add(input string n, input int rs1d, input int rs2d, input int rs1e,
                       input int rs2e, input int rde, input int rdm, input int rdw,
                       input logic rwm, input logic rww, input logic ld, input logic pc,
                       input logic mreq, input logic rdy, input logic [12:0] e);
        vec_t v;
        v.name = n;
        v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
        v.rde = 5'(rde); v.rdm = 5'(rdm); v.rdw = 5'(rdw);
        v.rwm = rwm; v.rww = rww; v.ld = ld; v.pc = pc; v.mreq = mreq; v.rdy = rdy;
        v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
        RdM = v.rdm; RdW = v.rdw; RegWriteM = v.rwm; RegWriteW = v.rww;
        ResultSrcE0 = v.ld; PCSrcE = v.pc; MemReqM = v.mreq; DmemReady = v.rdy;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; MemReqM = 0; DmemReady = 0;
    endtask

    // Called at a negedge with rst just released: 4 INIT cycles, then RUN.
    task automatic init_seq(input string tag);
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("%s_init_c%0d", tag, i), outs(), INIT_EXP);
            @(negedge clk);
        end
        #1 check({tag, "_run_after_init"}, outs(), run_exp(2'b00, 2'b00, 0, 0, 0, 0, 0));
        @(negedge clk);
    endtask

    initial begin
        // Table: all vectors stay in RUN (no memory stall), so each is independent.
        add("fwdA_M",      0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0, run_exp(2'b10, 2'b00, 0, 0, 0, 0, 0));
        add("fwdA_W",      0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 0, 0, run_exp(2'b01, 2'b00, 0, 0, 0, 0, 0));
        add("fwd_x0",      0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, run_exp(2'b00, 2'b00, 0, 0, 0, 0, 0));
        add("fwdA_M_B_W",  0, 0, 3, 9, 0, 3, 9, 1, 1, 0, 0, 0, 0, run_exp(2'b10, 2'b01, 0, 0, 0, 0, 0));
        add("fwdB_M_prio", 0, 0, 4, 6, 0, 6, 6, 1, 1, 0, 0, 0, 0, run_exp(2'b00, 2'b10, 0, 0, 0, 0, 0));
        add("lw_rs2",      1, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, run_exp(2'b00, 2'b00, 1, 1, 0, 1, 0));
        add("lw_x0",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, run_exp(2'b00, 2'b00, 0, 0, 0, 0, 0));
        add("lw_branch",   7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, run_exp(2'b00, 2'b00, 1, 1, 1, 1, 0));
        add("branch",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, run_exp(2'b00, 2'b00, 0, 0, 1, 1, 0));
        add("no_load",     7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, run_exp(2'b00, 2'b00, 0, 0, 0, 0, 0));
        add("mem_ready",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, run_exp(2'b00, 2'b00, 0, 0, 0, 0, 1));
        add("lw_and_fwd",  8, 0, 8, 0, 8, 8, 0, 1, 0, 1, 0, 0, 0, run_exp(2'b10, 2'b00, 1, 1, 0, 1, 0));

        // Reset values hold even with hazards on the inputs.
        rst = 1'b0;
        idle();
        RegWriteM = 1; RdM = 5; Rs1E = 5; ResultSrcE0 = 1; RdE = 7; Rs2D = 7; MemReqM = 1;
        #1 check("reset_outs", outs(), INIT_EXP);
        check("reset_memerr", {12'b0, MemErr}, 13'd0);
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        init_seq("por");

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1 check(tbl[i].name, outs(), tbl[i].exp);
            @(negedge clk);
        end
        idle();
        @(negedge clk);

        // Memory stall for 3 cycles overrides concurrent load-use and branch.
        MemReqM = 1; DmemReady = 0; ResultSrcE0 = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("memwait_c%0d", k), outs(), MEMS_EXP);
            @(negedge clk);
        end
        DmemReady = 1;
        #1 check("memwait_release", outs(), run_exp(2'b00, 2'b00, 1, 1, 1, 1, 1));
        @(negedge clk);
        idle();
        #1 check("memwait_back_run", outs(), run_exp(2'b00, 2'b00, 0, 0, 0, 0, 0));
        check("memwait_no_err", {12'b0, MemErr}, 13'd0);
        @(negedge clk);

        // MemReqM dropping inside MEM_WAIT returns to RUN behaviour.
        MemReqM = 1; DmemReady = 0;
        @(negedge clk);
        MemReqM = 0;
        #1 check("req_drop", outs(), run_exp(2'b00, 2'b00, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1 check("req_drop_run", outs(), run_exp(2'b00, 2'b00, 0, 0, 0, 0, 0));
        @(negedge clk);

        // Timeout: wait count equals the number of stalled edges; flag at 8.
        MemReqM = 1; DmemReady = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #1 check($sformatf("timeout_k%0d", k), {12'b0, MemErr}, {12'b0, (k >= 8)});
        end
        check("timeout_still_stalled", outs(), MEMS_EXP);
        DmemReady = 1;
        @(negedge clk);
        idle();
        #1 check("memerr_sticky", {12'b0, MemErr}, 13'd1);
        check("after_timeout_run", outs(), run_exp(2'b00, 2'b00, 0, 0, 0, 0, 0));

        // Asynchronous reset in the middle of a wait, away from any clock edge.
        MemReqM = 1; DmemReady = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_rst_outs", outs(), INIT_EXP);
        check("async_rst_memerr", {12'b0, MemErr}, 13'd0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        init_seq("rerst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
